io_slot_scheduler: RTL and testbench
====================================

IO_SLOT_SCHEDULER -- requirements
Module: io_slot_scheduler

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, SHALL set the number of cycles per grant; legal range 1..255.
REQ-002 Parameter NREQ, default 4, SHALL set the number of requesters; fixed at 4 in this revision.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 ena  input  1  SHALL enable the scheduler when high.
REQ-006 req  input  4  SHALL carry one request bit per requester, level-sensitive.
REQ-007 din  input  32  SHALL carry requester data, requester i on bits [8i+7:8i].
REQ-008 grant  output  4  SHALL be the one-hot grant, registered.
REQ-009 done  output  4  SHALL be a one-hot, one-cycle pulse on the last cycle of a grant, registered.
REQ-010 uo_data  output  8  SHALL drive the shared output pins, registered.
REQ-011 uo_valid  output  1  SHALL be high while uo_data carries granted data, registered.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT, GAP.
REQ-013 In IDLE or GAP with ena high and req nonzero, the next state SHALL be GRANT; otherwise IDLE.
REQ-014 Arbitration SHALL be round-robin: search starts at index (last+1) mod 4, upward with wrap, where last is the most recently granted index.
REQ-015 On entry to GRANT the winner's din byte SHALL be latched; uo_data SHALL hold that byte for the whole grant regardless of later din changes.
REQ-016 Entry to GRANT SHALL occur on the edge after the deciding cycle: grant one-hot, uo_valid=1, uo_data=latched byte from that edge.
REQ-017 A hold counter SHALL load HOLD_CYCLES-1 on entry to GRANT and decrement each cycle; GRANT SHALL last exactly HOLD_CYCLES cycles.
REQ-018 Deasserting req during GRANT SHALL NOT shorten the grant.
REQ-019 done[i] SHALL be high only in the final GRANT cycle (counter = 0) of requester i.
REQ-020 After the final GRANT cycle the next state SHALL be GAP for exactly one cycle: grant=0, uo_valid=0, uo_data=0x00.
REQ-021 In IDLE: grant=0, done=0, uo_valid=0, uo_data=0x00.
REQ-022 Requests SHALL be sampled only in IDLE/GAP; a request rising mid-GRANT SHALL wait.
REQ-023 With HOLD_CYCLES=1, GRANT SHALL last one cycle and done SHALL coincide with that cycle.
REQ-024 ena low in GRANT SHALL abort at the next edge to IDLE, no done pulse, last updated to the aborted index.
REQ-025 ena low in IDLE/GAP SHALL force IDLE and ignore req.
REQ-026 A single persistent requester SHALL be regranted with period HOLD_CYCLES+1 (GRANT then GAP).

Reset
REQ-027 rst_n low SHALL immediately force IDLE, grant=0, done=0, uo_valid=0, uo_data=0x00, counter=0, last=3 (so index 0 wins first).
REQ-028 Reset asserted mid-GRANT SHALL drop all outputs asynchronously with no done pulse.
REQ-029 After rst_n release the first arbitration SHALL occur on the first rising edge with ena high.

Verification
REQ-030 Reset, ena=1, req=0001, din[7:0]=0xA5 -> grant=0001, uo_data=0xA5, uo_valid=1 for 4 cycles, done=0001 in cycle 4, then 1 GAP cycle with uo_data=0x00.
REQ-031 req=1111 held, din bytes 0x10/0x21/0x32/0x43 -> grants 0,1,2,3,0 in order, each 4 cycles separated by 1 GAP cycle.
REQ-032 req=0100 granted, din[23:16] changed 0x55->0xAA and req dropped in cycle 2 -> uo_data stays 0x55 for all 4 cycles, done=0100 in cycle 4.
REQ-033 ena dropped in grant cycle 2 of requester 1 -> next cycle IDLE, all outputs 0, no done; ena restored with req=1111 -> requester 2 granted.
REQ-034 rst_n pulsed low mid-GRANT -> outputs 0 immediately without clock; after release req=1010 -> requester 1 granted first.
REQ-035 HOLD_CYCLES=1, req=0011 held -> grant alternates 0001, GAP, 0010, GAP, with done equal to grant each grant cycle.

Source files
------------

// File: rtl/io_slot_scheduler.sv
// io_slot_scheduler
//   Round-robin scheduler that hands a shared 8-bit output port to one of
//   NREQ requesters at a time. Each grant lasts HOLD_CYCLES cycles. A single
//   idle GAP cycle always follows a completed grant.
//
// Ports
//   clk       : single clock, rising-edge active
//   rst_n     : asynchronous, active-low reset
//   ena       : scheduler enable; low aborts a grant or holds the block idle
//   req       : level-sensitive request bits, one per requester
//   din       : requester data, requester i on bits [8i+7:8i]
//   grant     : registered one-hot grant
//   done      : registered one-hot pulse on the final cycle of a grant
//   uo_data   : registered shared output byte (0x00 when not granted)
//   uo_valid  : registered, high while uo_data carries granted data
module io_slot_scheduler #(
  parameter int HOLD_CYCLES = 4,
  parameter int NREQ        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] din,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        uo_data,
  output logic              uo_valid
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  logic [1:0]      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [1:0]      last_q, last_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;

  logic            win_found;
  logic [1:0]      win_idx;
  logic [NREQ-1:0] win_onehot;
  logic [7:0]      win_byte;

  // Round-robin search: start one past the last winner and wrap, so the
  // last winner itself is considered only after every other requester.
  always_comb begin
    logic [1:0] cand;
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = last_q;
    for (int k = 1; k <= NREQ; k++) begin
      cand = last_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_onehot = NREQ'(1) << win_idx;
  assign win_byte   = din[{win_idx, 3'b000} +: 8];

  // Next-state logic. Outputs default to zero so that IDLE, GAP and an
  // aborted grant all present a quiet port.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = '0;
    done_d  = '0;
    data_d  = 8'h00;
    valid_d = 1'b0;
    case (state_q)
      ST_GRANT: begin
        if (!ena) begin
          // Abort: no done pulse; last already points at this requester.
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'd0) begin
          state_d = ST_GAP;
        end else begin
          // Requests are ignored here; the grant runs to completion.
          cnt_d   = cnt_q - 8'd1;
          grant_d = grant_q;
          data_d  = data_q;
          valid_d = 1'b1;
          done_d  = (cnt_q == 8'd1) ? grant_q : '0;
        end
      end
      default: begin
        if (ena && win_found) begin
          state_d = ST_GRANT;
          cnt_d   = HOLD_LOAD;
          last_d  = win_idx;
          grant_d = win_onehot;
          data_d  = win_byte;
          valid_d = 1'b1;
          // A one-cycle grant is its own final cycle.
          done_d  = (HOLD_LOAD == 8'd0) ? win_onehot : '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // last resets to 3 so requester 0 is the first candidate after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      last_q  <= 2'd3;
      grant_q <= '0;
      done_q  <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign grant    = grant_q;
  assign done     = done_q;
  assign uo_data  = data_q;
  assign uo_valid = valid_q;

endmodule

// File: tb/tb_io_slot_scheduler.sv
module tb_io_slot_scheduler;

   typedef struct {
      int         edgeNum;
      logic [3:0] grant;
      logic [3:0] done;
      logic [7:0] data;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        ena;
   logic [3:0]  req;
   logic [31:0] din;

   logic [3:0]  grantA, doneA, grantB, doneB;
   logic [7:0]  dataA, dataB;
   logic        validA, validB;

   exp_t        expQueueA[$];
   exp_t        expQueueB[$];

   int          checkCount = 0;
   int          errorCount = 0;
   int          edgeCount  = 0;

   // Reference model state, one slot per DUT instance: how many grant
   // cycles are still owed, who owns the port, what byte it shows.
   int          holdLen[2] = '{4, 1};
   int          remaining[2];
   int          owner[2];
   int          lastIdx[2];
   logic [7:0]  heldByte[2];

   // Instance A uses the default four-cycle hold.
   io_slot_scheduler #(.HOLD_CYCLES(4), .NREQ(4)) dutA (
      .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .din(din),
      .grant(grantA), .done(doneA), .uo_data(dataA), .uo_valid(validA)
   );

   // Instance B shares the stimulus but grants for a single cycle.
   io_slot_scheduler #(.HOLD_CYCLES(1), .NREQ(4)) dutB (
      .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .din(din),
      .grant(grantB), .done(doneB), .uo_data(dataB), .uo_valid(validB)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count rising edges so expected entries can be tied to a specific edge.
   always @(posedge clk) edgeCount <= edgeCount + 1;

   // Hard time limit so the bench can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   // Predict what the coming rising edge produces from the inputs just
   // driven. Output happens only while a grant is owed; a grant that
   // finishes leaves one quiet cycle before a new winner can be chosen.
   task automatic modelStep(input int inst);
      exp_t e;
      bit   emit;
      bit   found;
      int   c;
      emit = 1'b0;
      if (remaining[inst] > 0) begin
         if (!ena) begin
            remaining[inst] = 0;
         end else begin
            remaining[inst] = remaining[inst] - 1;
            emit = (remaining[inst] > 0);
         end
      end else if (ena && req != 4'b0000) begin
         found = 1'b0;
         for (int k = 1; k <= 4; k++) begin
            c = (lastIdx[inst] + k) % 4;
            if (!found && req[c]) begin
               found = 1'b1;
               owner[inst] = c;
            end
         end
         lastIdx[inst]   = owner[inst];
         heldByte[inst]  = din[owner[inst]*8 +: 8];
         remaining[inst] = holdLen[inst];
         emit = 1'b1;
      end
      if (emit) begin
         e.edgeNum = edgeCount + 1;
         e.grant   = 4'b0001 << owner[inst];
         e.data    = heldByte[inst];
         e.done    = (remaining[inst] == 1) ? e.grant : 4'b0000;
         if (inst == 0) expQueueA.push_back(e);
         else           expQueueB.push_back(e);
      end
   endtask

   // Reset brings the model back to "nothing owed, requester 0 first".
   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         remaining[i] = 0;
         owner[i]     = 0;
         lastIdx[i]   = 3;
         heldByte[i]  = 8'h00;
      end
      expQueueA.delete();
      expQueueB.delete();
   endtask

   // Drive one cycle of inputs shortly after the falling edge and let the
   // model predict the following rising edge.
   task automatic applyStimulus(input bit e, input logic [3:0] r, input logic [31:0] d);
      @(negedge clk);
      #1;
      ena = e;
      req = r;
      din = d;
      if (rst_n) begin
         modelStep(0);
         modelStep(1);
      end
   endtask

   // Compare one instance's outputs against the head of its queue. A valid
   // cycle must match the next expected entry exactly, including the edge it
   // was predicted for; a quiet cycle must be all-zero and must not leave an
   // overdue expected entry behind.
   task automatic checkOutput(input int inst, input logic [3:0] g, input logic [3:0] d,
                              input logic [7:0] u, input logic v);
      exp_t e;
      bit   have;
      have = (inst == 0) ? (expQueueA.size() > 0) : (expQueueB.size() > 0);
      if (have) e = (inst == 0) ? expQueueA[0] : expQueueB[0];
      checkCount++;
      if (v) begin
         if (!have) begin
            errorCount++;
            $display("[TB] FAIL unexpected_valid inst%0d edge=%0d got grant=%b done=%b data=%h, required no output",
                     inst, edgeCount, g, d, u);
         end else begin
            if (inst == 0) void'(expQueueA.pop_front());
            else           void'(expQueueB.pop_front());
            if (e.edgeNum != edgeCount || g !== e.grant || d !== e.done || u !== e.data) begin
               errorCount++;
               $display("[TB] FAIL grant_cycle inst%0d got edge=%0d grant=%b done=%b data=%h, required edge=%0d grant=%b done=%b data=%h",
                        inst, edgeCount, g, d, u, e.edgeNum, e.grant, e.done, e.data);
            end
         end
      end else begin
         if (have && e.edgeNum <= edgeCount) begin
            errorCount++;
            $display("[TB] FAIL missing_grant inst%0d edge=%0d got valid=0, required grant=%b done=%b data=%h at edge=%0d",
                     inst, edgeCount, e.grant, e.done, e.data, e.edgeNum);
            if (inst == 0) void'(expQueueA.pop_front());
            else           void'(expQueueB.pop_front());
         end else if (g !== 4'b0000 || d !== 4'b0000 || u !== 8'h00 || v !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL idle_outputs inst%0d edge=%0d got grant=%b done=%b data=%h valid=%b, required all zero",
                     inst, edgeCount, g, d, u, v);
         end
      end
   endtask

   // Monitor: on every falling edge, look at both instances independently
   // of whatever the stimulus process is doing.
   always @(negedge clk) begin
      checkOutput(0, grantA, doneA, dataA, validA);
      checkOutput(1, grantB, doneB, dataB, validB);
   end

   // Outputs must be quiet right after reset asserts, without any clock.
   task automatic checkResetQuiet(input string tag);
      checkCount++;
      if (grantA !== 4'b0 || doneA !== 4'b0 || dataA !== 8'h00 || validA !== 1'b0 ||
          grantB !== 4'b0 || doneB !== 4'b0 || dataB !== 8'h00 || validB !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL %s got A=%b/%b/%h/%b B=%b/%b/%h/%b, required all zero",
                  tag, grantA, doneA, dataA, validA, grantB, doneB, dataB, validB);
      end
   endtask

   // Assert reset between clock edges, check it takes effect asynchronously,
   // hold it for two cycles, then release with the scheduler disabled.
   task automatic pulseReset();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkResetQuiet("reset_async");
      modelReset();
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      ena   = 1'b0;
      req   = 4'b0000;
      modelStep(0);
      modelStep(1);
   endtask

   // Main sequence: the directed scenarios first, then a randomized run.
   initial begin
      logic [3:0]  rndReq;
      logic [31:0] rndDin;
      bit          rndEna;
      int          holdFor;

      rst_n = 1'b1;
      ena   = 1'b0;
      req   = 4'b0000;
      din   = 32'h0;
      modelReset();
      #1;
      rst_n = 1'b0;
      #2;
      checkResetQuiet("reset_state");
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      modelStep(0);
      modelStep(1);

      $display("[TB] single requester 0 with data A5");
      repeat (7) applyStimulus(1'b1, 4'b0001, 32'h000000A5);
      repeat (3) applyStimulus(1'b1, 4'b0000, 32'h0);

      $display("[TB] all four requesting, round robin");
      pulseReset();
      repeat (27) applyStimulus(1'b1, 4'b1111, 32'h43322110);
      repeat (3) applyStimulus(1'b1, 4'b0000, 32'h0);

      $display("[TB] requester 2 data change and request drop mid grant");
      pulseReset();
      repeat (2) applyStimulus(1'b1, 4'b0100, 32'h00550000);
      repeat (6) applyStimulus(1'b1, 4'b0000, 32'h00AA0000);

      $display("[TB] enable dropped in grant cycle 2 of requester 1");
      pulseReset();
      repeat (2) applyStimulus(1'b1, 4'b0010, 32'h44332211);
      applyStimulus(1'b0, 4'b0010, 32'h44332211);
      repeat (2) applyStimulus(1'b0, 4'b1111, 32'h44332211);
      repeat (7) applyStimulus(1'b1, 4'b1111, 32'h44332211);
      repeat (3) applyStimulus(1'b1, 4'b0000, 32'h0);

      $display("[TB] reset mid grant, then requesters 1 and 3");
      repeat (2) applyStimulus(1'b1, 4'b1111, 32'hDDCCBBAA);
      pulseReset();
      repeat (12) applyStimulus(1'b1, 4'b1010, 32'hDDCCBBAA);
      repeat (3) applyStimulus(1'b1, 4'b0000, 32'h0);

      $display("[TB] requesters 0 and 1 held");
      pulseReset();
      repeat (10) applyStimulus(1'b1, 4'b0011, 32'h00002B1A);
      repeat (3) applyStimulus(1'b1, 4'b0000, 32'h0);

      // Randomized phase: requests held for random stretches, data changing
      // every cycle, enable occasionally low, rare mid-run resets.
      $display("[TB] randomized run");
      rndReq  = 4'b0000;
      holdFor = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (holdFor == 0) begin
            rndReq  = 4'($urandom_range(0, 15));
            holdFor = $urandom_range(1, 12);
         end
         holdFor = holdFor - 1;
         rndEna  = ($urandom_range(0, 11) != 0);
         rndDin  = $urandom;
         if ($urandom_range(0, 199) == 0) pulseReset();
         else applyStimulus(rndEna, rndReq, rndDin);
      end

      repeat (8) applyStimulus(1'b0, 4'b0000, 32'h0);
      @(negedge clk);
      #1;

      // Nothing predicted may be left unobserved.
      checkCount++;
      if (expQueueA.size() != 0 || expQueueB.size() != 0) begin
         errorCount++;
         $display("[TB] FAIL queue_drain got pending A=%0d B=%0d, required 0",
                  expQueueA.size(), expQueueB.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, errorCount);
      $finish;
   end

endmodule
